packet_source_arbiter: RTL and testbench

Shares one packet_parser input port between N_SRC upstream packet sources. Grants one source at a time, round-robin, with packet-granular locking. Forwards the granted source's data/valid to the parser and returns parser ready to that source only. Releases the grant after exactly PKT_WORDS accepted beats. Sits directly upstream of packet_parser.

---
 rtl/pkt_pkg.sv | 15 +
 rtl/rr_pick.sv | 31 +++
 rtl/packet_source_arbiter.sv | 127 ++++++++++++
 tb/tb_packet_source_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_pkg.sv
// Shared packet-format definitions for the packet parser and its upstream arbiter.
// Packet length is defined here once so both blocks agree on framing.
package pkt_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int ETH_WORDS         = 4;
  localparam int IP_WORDS          = 5;
  localparam int TCP_WORDS         = 5;
  localparam int PKT_WORDS_DEFAULT = 25;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: grants the first requester at or
// above ptr, wrapping modulo N_SRC.
module rr_pick #(
  parameter int N_SRC = 4,
  parameter int PTR_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_SRC-1:0] gnt,
  output logic             any_req
);

  logic found;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int off = 0; off < N_SRC; off++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!found && req[i] && (i == (int'(ptr) + off) % N_SRC)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/packet_source_arbiter.sv
// Round-robin, packet-locked arbiter sharing one packet_parser input between
// N_SRC sources; the grant is held for exactly PKT_WORDS accepted beats.
module packet_source_arbiter
  import pkt_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int N_SRC     = 4,
  parameter int PKT_WORDS = PKT_WORDS_DEFAULT,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [N_SRC-1:0]       src_valid,
  output logic [N_SRC-1:0]       src_ready,
  output logic [WIDTH-1:0]       par_data,
  output logic                   par_valid,
  input  logic                   par_ready,
  output logic [N_SRC-1:0]       grant,
  output logic                   busy,
  output logic [CNT_W-1:0]       pkts_done
);

  localparam int PTR_W  = $clog2(N_SRC);
  localparam int BEAT_W = $clog2(PKT_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_WORDS - 1);
  localparam logic [PTR_W-1:0]  LAST_SRC  = PTR_W'(N_SRC - 1);

  arb_state_t        state_q, state_d;
  logic [N_SRC-1:0]  grant_q, grant_d;
  logic              busy_q, busy_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  pkts_q, pkts_d;

  logic [N_SRC-1:0]  pick_gnt;
  logic              any_req;
  logic [PTR_W-1:0]  grant_idx;
  logic              beat;

  rr_pick #(
    .N_SRC (N_SRC),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (src_valid),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .any_req (any_req)
  );

  // With no grant held the mux drives zeros, so nothing undefined reaches the parser.
  always_comb begin
    par_data  = '0;
    par_valid = 1'b0;
    src_ready = '0;
    grant_idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q[i]) begin
        par_data     = src_data[i*WIDTH +: WIDTH];
        par_valid    = src_valid[i];
        src_ready[i] = par_ready;
        grant_idx    = PTR_W'(i);
      end
    end
  end

  assign beat = par_valid && par_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    beat_d  = beat_q;
    ptr_d   = ptr_q;
    pkts_d  = pkts_q;
    case (state_q)
      ARB: begin
        if (any_req) begin
          grant_d = pick_gnt;
          busy_d  = 1'b1;
          beat_d  = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        // Stalls on either side simply leave beat_q untouched; only traffic ends the lock.
        if (beat) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ARB;
            grant_d = '0;
            busy_d  = 1'b0;
            beat_d  = '0;
            ptr_d   = (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;
            if (pkts_q != '1) pkts_d = pkts_q + 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB;
      grant_q <= '0;
      busy_q  <= 1'b0;
      beat_q  <= '0;
      ptr_q   <= '0;
      pkts_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      beat_q  <= beat_d;
      ptr_q   <= ptr_d;
      pkts_q  <= pkts_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign pkts_done = pkts_q;

endmodule

// File: tb/tb_packet_source_arbiter.sv
// Scoreboard bench for packet_source_arbiter: directed traffic pushes expected
// grants and words; a negedge monitor pops and compares what the DUT forwards.
module tb_packet_source_arbiter;
  import pkt_pkg::*;

  localparam int WIDTH = 32;
  localparam int N_SRC = 4;
  localparam int PKT   = PKT_WORDS_DEFAULT;
  localparam int CNT_W = 16;
  localparam int SAT_W = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_SRC*WIDTH-1:0] src_data;
  logic [N_SRC-1:0]       src_valid, src_ready, grant, en;
  logic [WIDTH-1:0]       par_data;
  logic                   par_valid, par_ready, busy;
  logic [CNT_W-1:0]       pkts_done;

  logic [N_SRC-1:0]       sat_src_ready, sat_grant;
  logic [WIDTH-1:0]       sat_par_data;
  logic                   sat_par_valid, sat_busy;
  logic [SAT_W-1:0]       sat_pkts;

  int wcnt  [N_SRC];
  int sent  [N_SRC];
  int limit [N_SRC];

  logic [WIDTH-1:0] data_q [$];
  logic [N_SRC-1:0] grant_q [$];
  logic [WIDTH-1:0] exp_w;
  logic [N_SRC-1:0] exp_g;
  logic [N_SRC-1:0] prev_grant = '0;
  logic             rel_pending = 1'b0;
  int checks = 0, failures = 0, pkt_beat = 0, exp_pkts = 0;

  always #5 clk = ~clk;

  packet_source_arbiter #(.WIDTH(WIDTH), .N_SRC(N_SRC), .PKT_WORDS(PKT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .par_data(par_data), .par_valid(par_valid), .par_ready(par_ready),
    .grant(grant), .busy(busy), .pkts_done(pkts_done)
  );

  packet_source_arbiter #(.WIDTH(WIDTH), .N_SRC(N_SRC), .PKT_WORDS(PKT), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid), .src_ready(sat_src_ready),
    .par_data(sat_par_data), .par_valid(sat_par_valid), .par_ready(par_ready),
    .grant(sat_grant), .busy(sat_busy), .pkts_done(sat_pkts)
  );

  // Upstream source model: word tag = {source, packet number, word index}.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_valid[i] = en[i] && (sent[i] < limit[i]);
      src_data[i*WIDTH +: WIDTH] = {8'(i), 8'(sent[i]), 16'(wcnt[i])};
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        wcnt[i] <= 0;
        sent[i] <= 0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          if (wcnt[i] == PKT - 1) begin
            wcnt[i] <= 0;
            sent[i] <= sent[i] + 1;
          end else begin
            wcnt[i] <= wcnt[i] + 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_pkt(input int src, input int pkt);
    grant_q.push_back(N_SRC'(1) << src);
    for (int w = 0; w < PKT; w++) data_q.push_back({8'(src), 8'(pkt), 16'(w)});
  endtask

  function automatic int sat_model(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  // Monitor: compares everything the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      data_q.delete();
      grant_q.delete();
      pkt_beat    = 0;
      exp_pkts    = 0;
      prev_grant  = '0;
      rel_pending = 1'b0;
    end else begin
      if (rel_pending) begin
        check("release_grant", grant, 0);
        check("release_busy", busy, 0);
        check("pkts_done", pkts_done, exp_pkts);
        check("sat_pkts_done", sat_pkts, sat_model(exp_pkts));
        rel_pending = 1'b0;
      end
      if (grant != 0 && prev_grant == 0) begin
        if (grant_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant actual=%b expected=none", grant);
        end else begin
          exp_g = grant_q.pop_front();
          check("grant_order", grant, exp_g);
        end
      end
      if (grant == 0 && prev_grant != 0) check("release_at_end", pkt_beat, 0);
      check("busy_vs_grant", busy, grant != 0);
      check("src_ready_mask", src_ready & ~grant, 0);
      if (grant == 0) check("idle_outputs", {par_valid, par_data}, 0);
      if (par_valid && par_ready) begin
        if (data_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h expected=none", par_data);
        end else begin
          exp_w = data_q.pop_front();
          check("par_data", par_data, exp_w);
          pkt_beat++;
          if (pkt_beat == PKT) begin
            pkt_beat    = 0;
            exp_pkts++;
            rel_pending = 1'b1;
          end
        end
      end
      prev_grant = grant;
    end
  end

  task automatic wait_idle(input string name);
    int budget = 2000;
    do begin
      @(posedge clk);
      #1;
      budget--;
    end while ((data_q.size() != 0 || grant_q.size() != 0 || busy || rel_pending) && budget > 0);
    if (budget == 0) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s actual=%0d_words_left expected=0", name, data_q.size());
    end
  endtask

  task automatic wait_beats(input int n);
    int budget = 500;
    while (pkt_beat < n && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) begin
      checks++;
      failures++;
      $display("FAIL timeout_beats actual=%0d expected=%0d", pkt_beat, n);
    end
  endtask

  initial begin
    rst       = 1'b1;
    en        = '0;
    par_ready = 1'b0;
    for (int i = 0; i < N_SRC; i++) limit[i] = 0;
    #2 rst = 1'b0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_pkts", pkts_done, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_par", {par_valid, par_data}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single source 2: granted one cycle after valid, 25 words in order.
    @(posedge clk);
    #1;
    expect_pkt(2, 0);
    limit[2]  = 1;
    en        = 4'b0100;
    par_ready = 1'b1;
    @(negedge clk);
    check("grant_before_edge", grant, 0);
    @(negedge clk);
    check("grant_latency", grant, 4'b0100);
    wait_idle("single");
    check("single_pkts", pkts_done, 1);

    // Skip idle: pointer at 3 -> source 1; then pointer 2 with 1,3 valid -> 3 then 1.
    expect_pkt(1, 0);
    limit[1] = 1;
    en       = 4'b0010;
    wait_idle("src1");
    expect_pkt(3, 0);
    expect_pkt(1, 1);
    limit[1] = 2;
    limit[3] = 1;
    en       = 4'b1010;
    wait_idle("skip_idle");

    // Backpressure and source stall on source 0 while source 1 also requests.
    expect_pkt(0, 0);
    expect_pkt(1, 2);
    limit[0] = 1;
    limit[1] = 3;
    en       = 4'b1011;
    wait_beats(7);
    par_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("stall_grant", grant, 4'b0001);
      check("stall_src_ready", src_ready, 0);
      check("stall_beats", pkt_beat, 7);
    end
    par_ready = 1'b1;
    wait_beats(15);
    en[0] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("drop_src_ready", src_ready, 4'b0001);
      check("drop_par_valid", par_valid, 0);
      check("drop_beats", pkt_beat, 15);
    end
    en[0] = 1'b1;
    wait_idle("backpressure");
    check("bp_pkts", pkts_done, 6);

    // Reset mid-packet from source 1, then pointer restarts at 0.
    expect_pkt(1, 3);
    limit[1] = 4;
    en       = 4'b0010;
    wait_beats(10);
    #2 rst = 1'b0;
    #1;
    check("midrst_grant", grant, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pkts", pkts_done, 0);
    check("midrst_src_ready", src_ready, 0);
    check("midrst_sat_pkts", sat_pkts, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N_SRC; i++) limit[i] = 0;
    limit[1] = 1;
    limit[3] = 1;
    en       = 4'b1010;
    expect_pkt(1, 0);
    expect_pkt(3, 0);
    rst = 1'b1;
    wait_idle("after_reset");

    // Round-robin with all sources valid: 0,1,2,3,0; counter saturates on u_sat.
    expect_pkt(0, 0);
    expect_pkt(1, 1);
    expect_pkt(2, 0);
    expect_pkt(3, 1);
    expect_pkt(0, 1);
    limit[0] = 2;
    limit[1] = 2;
    limit[2] = 1;
    limit[3] = 2;
    en       = 4'b1111;
    wait_idle("round_robin");
    check("rr_pkts", pkts_done, 7);
    check("rr_sat_pkts", sat_pkts, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
